// File: rtl/coinc_arb_pkg.sv
// ============================================================================
// coinc_arb_pkg : shared types and constants for the coincTrigger arbiter
// Optional feature macro: COINC_ARB_TIMEOUT_EN (adds the DRAIN state)
// Revision: 1.0
// ============================================================================
`default_nettype none

package coinc_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_DONE    = 3'd5
`ifdef COINC_ARB_TIMEOUT_EN
        ,
        ST_DRAIN   = 3'd6
`endif
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic req_idx_t;

    localparam logic [3:0] REG_OFS_0 = 4'h0;
    localparam logic [3:0] REG_OFS_1 = 4'h4;
    localparam logic [3:0] REG_OFS_2 = 4'h8;
    localparam logic [3:0] REG_OFS_3 = 4'hC;

endpackage

`default_nettype wire

// File: rtl/coinc_rr_arbiter.sv
// ============================================================================
// coinc_rr_arbiter : two-way round-robin grant with a last-grant register
// Revision: 1.0
// ============================================================================
`default_nettype none

module coinc_rr_arbiter
    import coinc_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic       o_grant,
    output logic       o_any
);

    req_idx_t r_last;

    // On a tie the requester not served last wins.
    always_comb begin
        o_grant = 1'b0;
        if (i_req == 2'b11) begin
            o_grant = ~r_last;
        end else if (i_req[1]) begin
            o_grant = 1'b1;
        end
    end

    assign o_any = |i_req;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (i_accept) begin
            r_last <= o_grant;
        end
    end

endmodule

`default_nettype wire

// File: rtl/coinc_reg_arbiter.sv
// ============================================================================
// coinc_reg_arbiter : shares one AXI4-Lite register port between two requesters
// Optional feature macro: COINC_ARB_TIMEOUT_EN (response timeout + DRAIN)
// Revision: 1.0
// ============================================================================
`default_nettype none

module coinc_reg_arbiter
    import coinc_arb_pkg::*;
#(
    parameter int C_ADDR_WIDTH = 4,
    parameter int C_DATA_WIDTH = 32,
    parameter int C_TIMEOUT    = 255
) (
    input  logic                                ACLK,
    input  logic                                ARESETN,
    input  logic [1:0]                          req_valid,
    output logic [1:0]                          req_ready,
    input  logic [1:0]                          req_write,
    input  logic [1:0][C_ADDR_WIDTH-1:0]        req_addr,
    input  logic [1:0][C_DATA_WIDTH-1:0]        req_wdata,
    output logic [1:0]                          rsp_valid,
    output logic [C_DATA_WIDTH-1:0]             rsp_rdata,
    output logic [1:0]                          rsp_resp,
    output logic [C_ADDR_WIDTH-1:0]             M_AXI_AWADDR,
    output logic [2:0]                          M_AXI_AWPROT,
    output logic                                M_AXI_AWVALID,
    input  logic                                M_AXI_AWREADY,
    output logic [C_DATA_WIDTH-1:0]             M_AXI_WDATA,
    output logic [3:0]                          M_AXI_WSTRB,
    output logic                                M_AXI_WVALID,
    input  logic                                M_AXI_WREADY,
    input  logic [1:0]                          M_AXI_BRESP,
    input  logic                                M_AXI_BVALID,
    output logic                                M_AXI_BREADY,
    output logic [C_ADDR_WIDTH-1:0]             M_AXI_ARADDR,
    output logic [2:0]                          M_AXI_ARPROT,
    output logic                                M_AXI_ARVALID,
    input  logic                                M_AXI_ARREADY,
    input  logic [C_DATA_WIDTH-1:0]             M_AXI_RDATA,
    input  logic [1:0]                          M_AXI_RRESP,
    input  logic                                M_AXI_RVALID,
    output logic                                M_AXI_RREADY
);

    state_t                    r_state;
    req_idx_t                  r_grant;
    logic [C_ADDR_WIDTH-1:0]   r_addr;
    logic [C_DATA_WIDTH-1:0]   r_wdata;
    logic                      r_awvalid;
    logic                      r_wvalid;
    logic                      r_aw_done;
    logic                      r_w_done;
    logic                      r_bready;
    logic                      r_arvalid;
    logic                      r_rready;
    logic [1:0]                r_req_ready;
    logic [1:0]                r_rsp_valid;
    logic [C_DATA_WIDTH-1:0]   r_rsp_rdata;
    logic [1:0]                r_rsp_resp;

    logic w_grant;
    logic w_any;
    logic w_accept;
    logic w_aw_fin;
    logic w_w_fin;

    assign w_accept = (r_state == ST_IDLE) && w_any;
    assign w_aw_fin = r_aw_done | (r_awvalid & M_AXI_AWREADY);
    assign w_w_fin  = r_w_done  | (r_wvalid  & M_AXI_WREADY);

    coinc_rr_arbiter u_rr (
        .clk      (ACLK),
        .rst_n    (ARESETN),
        .i_req    (req_valid),
        .i_accept (w_accept),
        .o_grant  (w_grant),
        .o_any    (w_any)
    );

`ifdef COINC_ARB_TIMEOUT_EN
    localparam int                  c_cnt_w    = $clog2(C_TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0]  c_tmo_last = c_cnt_w'(C_TIMEOUT - 1);
    logic [c_cnt_w-1:0] r_tmo_cnt;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (C_TIMEOUT == 0);
`endif

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state     <= ST_IDLE;
            r_grant     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= RESP_OKAY;
`ifdef COINC_ARB_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
        end else begin
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_req_ready[w_grant] <= 1'b1;
                        r_grant   <= w_grant;
                        r_addr    <= {req_addr[w_grant][C_ADDR_WIDTH-1:2], 2'b00};
                        r_wdata   <= req_wdata[w_grant];
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= req_write[w_grant] ? ST_WR_REQ : ST_RD_REQ;
                    end
                end
                // AW and W rise together but retire independently.
                ST_WR_REQ: begin
                    if (r_awvalid && M_AXI_AWREADY) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end else if (!r_aw_done) begin
                        r_awvalid <= 1'b1;
                    end
                    if (r_wvalid && M_AXI_WREADY) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end else if (!r_w_done) begin
                        r_wvalid <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_WR_RESP;
`ifdef COINC_ARB_TIMEOUT_EN
                        r_tmo_cnt <= '0;
`endif
                    end
                end
                ST_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        r_bready    <= 1'b0;
                        r_rsp_resp  <= M_AXI_BRESP;
                        r_rsp_rdata <= '0;
                        r_rsp_valid[r_grant] <= 1'b1;
                        r_state     <= ST_DONE;
                    end
`ifdef COINC_ARB_TIMEOUT_EN
                    else if (r_tmo_cnt == c_tmo_last) begin
                        r_rsp_resp  <= RESP_SLVERR;
                        r_rsp_rdata <= '0;
                        r_rsp_valid[r_grant] <= 1'b1;
                        r_state     <= ST_DRAIN;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + c_cnt_w'(1);
                    end
`endif
                end
                ST_RD_REQ: begin
                    if (r_arvalid && M_AXI_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RD_RESP;
`ifdef COINC_ARB_TIMEOUT_EN
                        r_tmo_cnt <= '0;
`endif
                    end else begin
                        r_arvalid <= 1'b1;
                    end
                end
                ST_RD_RESP: begin
                    if (M_AXI_RVALID) begin
                        r_rready    <= 1'b0;
                        r_rsp_resp  <= M_AXI_RRESP;
                        r_rsp_rdata <= M_AXI_RDATA;
                        r_rsp_valid[r_grant] <= 1'b1;
                        r_state     <= ST_DONE;
                    end
`ifdef COINC_ARB_TIMEOUT_EN
                    else if (r_tmo_cnt == c_tmo_last) begin
                        r_rsp_resp  <= RESP_SLVERR;
                        r_rsp_rdata <= '0;
                        r_rsp_valid[r_grant] <= 1'b1;
                        r_state     <= ST_DRAIN;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + c_cnt_w'(1);
                    end
`endif
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
`ifdef COINC_ARB_TIMEOUT_EN
                // Requester already got SLVERR; swallow the late response.
                ST_DRAIN: begin
                    if ((r_bready && M_AXI_BVALID) || (r_rready && M_AXI_RVALID)) begin
                        r_bready <= 1'b0;
                        r_rready <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule

`default_nettype wire

// File: tb/tb_coinc_reg_arbiter.sv
// ============================================================================
// tb_coinc_reg_arbiter : scoreboard bench with a small AXI4-Lite slave model
// Optional feature macro: COINC_ARB_TIMEOUT_EN (enables the timeout scenario)
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_coinc_reg_arbiter;
    import coinc_arb_pkg::*;

`ifdef COINC_ARB_TIMEOUT_EN
    localparam int c_tmo = 8;
`else
    localparam int c_tmo = 255;
`endif

    logic             ACLK = 1'b0;
    logic             ARESETN = 1'b0;
    logic [1:0]       req_valid = '0;
    logic [1:0]       req_ready;
    logic [1:0]       req_write = '0;
    logic [1:0][3:0]  req_addr = '0;
    logic [1:0][31:0] req_wdata = '0;
    logic [1:0]       rsp_valid;
    logic [31:0]      rsp_rdata;
    logic [1:0]       rsp_resp;
    logic [3:0]       AWADDR, ARADDR;
    logic [2:0]       AWPROT, ARPROT;
    logic             AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic             ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0]      WDATA, RDATA;
    logic [3:0]       WSTRB;
    logic [1:0]       BRESP, RRESP;

    always #5 ACLK = ~ACLK;

    coinc_reg_arbiter #(.C_ADDR_WIDTH(4), .C_DATA_WIDTH(32), .C_TIMEOUT(c_tmo)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID),
        .M_AXI_AWREADY(AWREADY), .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB),
        .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY), .M_AXI_BRESP(BRESP),
        .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY), .M_AXI_ARADDR(ARADDR),
        .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
        .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID),
        .M_AXI_RREADY(RREADY)
    );

    // ---------------- slave model ----------------
    logic [31:0] s_mem [4];
    logic        s_got_aw, s_got_w, s_bvalid, s_bpend, s_rvalid, s_rpend;
    logic [3:0]  s_awaddr;
    logic [31:0] s_wdata, s_rdata;
    int          s_w_wait;
    int          w_delay = 0;
    logic        b_en = 1'b1;
    logic        r_en = 1'b1;

    assign AWREADY = AWVALID;
    assign WREADY  = WVALID && (s_w_wait >= w_delay);
    assign ARREADY = ARVALID;
    assign BVALID  = s_bvalid;
    assign BRESP   = RESP_OKAY;
    assign RVALID  = s_rvalid;
    assign RDATA   = s_rdata;
    assign RRESP   = RESP_OKAY;

    wire        s_aw_hs   = AWVALID & AWREADY;
    wire        s_w_hs    = WVALID & WREADY;
    wire        s_ar_hs   = ARVALID & ARREADY;
    wire        s_have_aw = s_got_aw | s_aw_hs;
    wire        s_have_w  = s_got_w | s_w_hs;
    wire [3:0]  s_wa      = s_aw_hs ? AWADDR : s_awaddr;
    wire [31:0] s_wd      = s_w_hs ? WDATA : s_wdata;

    always @(posedge ACLK) begin
        if (!ARESETN) begin
            s_got_aw <= 1'b0; s_got_w <= 1'b0; s_bvalid <= 1'b0; s_bpend <= 1'b0;
            s_rvalid <= 1'b0; s_rpend <= 1'b0; s_w_wait <= 0;
        end else begin
            if (s_aw_hs) s_awaddr <= AWADDR;
            if (s_w_hs)  s_wdata  <= WDATA;
            if (WVALID && !WREADY) s_w_wait <= s_w_wait + 1;
            else                   s_w_wait <= 0;
            if (s_bvalid && BREADY) s_bvalid <= 1'b0;
            if (s_have_aw && s_have_w) begin
                s_mem[s_wa[3:2]] <= s_wd;
                s_got_aw <= 1'b0;
                s_got_w  <= 1'b0;
                if (b_en) s_bvalid <= 1'b1;
                else      s_bpend  <= 1'b1;
            end else begin
                s_got_aw <= s_have_aw;
                s_got_w  <= s_have_w;
            end
            if (s_bpend && b_en) begin
                s_bpend  <= 1'b0;
                s_bvalid <= 1'b1;
            end
            if (s_rvalid && RREADY) s_rvalid <= 1'b0;
            if (s_ar_hs) begin
                s_rdata <= s_mem[ARADDR[3:2]];
                if (r_en) s_rvalid <= 1'b1;
                else      s_rpend  <= 1'b1;
            end
            if (s_rpend && r_en) begin
                s_rpend  <= 1'b0;
                s_rvalid <= 1'b1;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        logic        idx;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          lat;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0, rr_cyc = 0, aw_cyc = 0, w_cyc = 0, b_hs = 0;
    logic [3:0] last_awaddr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_rsp(input int idx, input logic [31:0] rd, input logic [1:0] rs, input int lat);
        exp_t e;
        e.idx = idx[0]; e.rdata = rd; e.resp = rs; e.lat = lat;
        sb.push_back(e);
    endtask

    always @(negedge ACLK) begin
        cyc++;
        if (AWVALID) begin
            aw_cyc++;
            last_awaddr = AWADDR;
        end
        if (WVALID) w_cyc++;
        if (BVALID && BREADY) b_hs++;
        if (|req_ready) rr_cyc = cyc;
        if (|rsp_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_rsp: rsp_valid=%b with nothing pending", rsp_valid);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_valid_idx", {62'd0, rsp_valid}, mon_e.idx ? 64'd2 : 64'd1);
                check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, mon_e.rdata});
                check("rsp_resp", {62'd0, rsp_resp}, {62'd0, mon_e.resp});
                if (mon_e.lat >= 0) check("latency", 64'(cyc - rr_cyc), 64'(mon_e.lat));
            end
        end
    end

    function automatic logic [63:0] out_vec();
        return {21'd0, req_ready, rsp_valid, rsp_rdata, rsp_resp,
                AWVALID, WVALID, BREADY, ARVALID, RREADY};
    endfunction

    task automatic issue(input int idx, input logic wr, input logic [3:0] addr, input logic [31:0] wd);
        @(negedge ACLK);
        req_write[idx] = wr;
        req_addr[idx]  = addr;
        req_wdata[idx] = wd;
        req_valid[idx] = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge ACLK); #1;
            if (req_ready[idx]) break;
        end
        check("accept", {63'd0, req_ready[idx]}, 64'd1);
        req_valid[idx] = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge ACLK);
        check("drain_timeout", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge ACLK);
    endtask

    int aw0, w0, b0, c0, c1;

    initial begin
        repeat (3) @(posedge ACLK);
        #1;
        check("reset_outputs", out_vec(), 64'd0);
        check("fixed_wstrb_prot", {57'd0, WSTRB, AWPROT[0] | ARPROT[0], AWPROT[2:1] | ARPROT[2:1]}, {57'd0, 4'hF, 3'b000});
        @(negedge ACLK) ARESETN = 1'b1;

        // writes then read-back from requester 0
        for (int i = 0; i < 4; i++) begin
            expect_rsp(0, 32'd0, RESP_OKAY, 3);
            issue(0, 1'b1, 4'(i * 4), 32'(i + 1));
            wait_drain();
        end
        for (int i = 0; i < 4; i++) begin
            expect_rsp(0, 32'(i + 1), RESP_OKAY, 3);
            issue(0, 1'b0, 4'(i * 4), 32'd0);
            wait_drain();
        end

        // delayed WREADY and address alignment
        aw0 = aw_cyc; w0 = w_cyc; b0 = b_hs;
        w_delay = 3;
        expect_rsp(0, 32'd0, RESP_OKAY, -1);
        issue(0, 1'b1, 4'h5, 32'hA5);
        wait_drain();
        w_delay = 0;
        check("awvalid_cycles", 64'(aw_cyc - aw0), 64'd1);
        check("wvalid_cycles", 64'(w_cyc - w0), 64'd4);
        check("b_handshakes", 64'(b_hs - b0), 64'd1);
        check("awaddr_aligned", {60'd0, last_awaddr}, 64'h4);

        // reset while waiting in the read-response phase
        r_en = 1'b0;
        issue(0, 1'b0, 4'h4, 32'd0);
        for (int k = 0; k < 20 && !RREADY; k++) @(negedge ACLK);
        check("rd_resp_reached", {63'd0, RREADY}, 64'd1);
        @(negedge ACLK) ARESETN = 1'b0;
        @(posedge ACLK); #1;
        check("midreset_outputs", out_vec(), 64'd0);
        @(negedge ACLK) ARESETN = 1'b1;
        r_en = 1'b1;
        expect_rsp(1, 32'hA5, RESP_OKAY, 3);
        issue(1, 1'b0, 4'h4, 32'd0);
        wait_drain();

        // both requesters continuously valid: grants must alternate 0,1,0,1
        expect_rsp(0, 32'd1, RESP_OKAY, 3);
        expect_rsp(1, 32'hA5, RESP_OKAY, 3);
        expect_rsp(0, 32'd3, RESP_OKAY, 3);
        expect_rsp(1, 32'd4, RESP_OKAY, 3);
        c0 = 0; c1 = 0;
        @(negedge ACLK);
        req_write = 2'b00;
        req_addr[0] = 4'h0;
        req_addr[1] = 4'h4;
        req_valid = 2'b11;
        for (int k = 0; k < 100 && req_valid != 2'b00; k++) begin
            @(posedge ACLK); #1;
            if (req_ready[0]) begin
                c0++;
                if (c0 == 2) req_valid[0] = 1'b0;
                else         req_addr[0] = 4'h8;
            end
            if (req_ready[1]) begin
                c1++;
                if (c1 == 2) req_valid[1] = 1'b0;
                else         req_addr[1] = 4'hC;
            end
        end
        check("fair_all_accepted", 64'(c0 * 16 + c1), 64'h22);
        req_valid = 2'b00;
        wait_drain();

`ifdef COINC_ARB_TIMEOUT_EN
        // slave withholds BVALID: SLVERR after the timeout, late B drained silently
        b_en = 1'b0;
        b0 = b_hs;
        expect_rsp(0, 32'd0, RESP_SLVERR, c_tmo + 2);
        issue(0, 1'b1, 4'h8, 32'h33);
        wait_drain();
        repeat (4) @(negedge ACLK);
        b_en = 1'b1;
        repeat (6) @(negedge ACLK);
        check("drain_b_handshakes", 64'(b_hs - b0), 64'd1);
        expect_rsp(0, 32'h33, RESP_OKAY, 3);
        issue(0, 1'b0, 4'h8, 32'd0);
        wait_drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/coinc_reg_arbiter.md
# coinc_reg_arbiter

Two-requester AXI4-Lite register-access arbiter for the coincTrigger peripheral. It shares the single S00_AXI register port (four 32-bit registers at 0x0/0x4/0x8/0xC) between two on-chip requesters, such as a run-control sequencer and a host bridge. It grants one simple request/response transaction at a time in round-robin order and sequences the AXI4-Lite AW/W/B or AR/R handshakes on the requester's behalf.

## Interface
Parameters:
- C_ADDR_WIDTH, 4, byte address width of the coincTrigger register space
- C_DATA_WIDTH, 32, register data width; only 32 is supported
- C_TIMEOUT, 255, cycles to wait for BVALID/RVALID before error completion; used only when the timeout feature is compiled in

Ports:
- ACLK  in  1  clock; all logic on the rising edge
- ARESETN  in  1  synchronous active-low reset
- req_valid  in  [1:0]  requester i has a pending transaction
- req_ready  out  [1:0]  one-cycle pulse when requester i's request is accepted
- req_write  in  [1:0]  1 = write, 0 = read
- req_addr  in  [1:0][C_ADDR_WIDTH-1:0]  byte address
- req_wdata  in  [1:0][31:0]  write data
- rsp_valid  out  [1:0]  one-cycle completion pulse to requester i
- rsp_rdata  out  32  read data; 0 for writes; valid with rsp_valid
- rsp_resp  out  2  AXI response code; valid with rsp_valid
- M_AXI_AWADDR/AWPROT/AWVALID out, AWREADY in; WDATA/WSTRB/WVALID out, WREADY in; BRESP/BVALID in, BREADY out
- M_AXI_ARADDR/ARPROT/ARVALID out, ARREADY in; RDATA/RRESP/RVALID in, RREADY out

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE, plus DRAIN when the timeout feature is compiled in.
- IDLE:
  - If any req_valid is high, grant it and pulse req_ready[g].
  - Latch write, addr (with addr[1:0] forced to 0) and wdata.
  - Go to WR_REQ or RD_REQ.
- Arbitration:
  - If both requesters are valid, grant the one not granted last.
  - last_grant resets to 1, so requester 0 wins the first tie.
- WR_REQ:
  - AWVALID and WVALID rise together.
  - Each drops independently after its own handshake; either channel may complete first.
  - Go to WR_RESP once both have completed.
- WR_RESP: BREADY=1. On BVALID, capture BRESP and go to DONE.
- RD_REQ: ARVALID=1 until ARREADY, then go to RD_RESP.
- RD_RESP: RREADY=1. On RVALID, capture RDATA/RRESP and go to DONE.
- DONE: rsp_valid[g]=1 for one cycle, then go to IDLE.
- Fixed outputs: WSTRB=4'hF; AWPROT=ARPROT=3'b000.
- The requester must hold req_* stable while req_valid is high and not yet accepted. req_valid may drop at any time before acceptance.

## Timing
- Reset values: every VALID/READY out = 0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_resp=0, state=IDLE, last_grant=1.
- All outputs are registered.
- Zero-wait slave, write:
  - cycle 0: req_ready
  - cycle 1: AW/W handshake
  - cycle 2: B handshake
  - cycle 3: rsp_valid
  - Total latency 3 cycles.
- Zero-wait slave, read: same cycle pattern with AR/R.
- Next acceptance is possible no earlier than the cycle after rsp_valid, so at most one transaction is outstanding.
- A request arriving in DONE waits until IDLE.
- ARESETN low mid-transaction:
  - State returns to IDLE at that edge.
  - Outputs take their reset values.
  - No rsp_valid is issued for the abandoned transaction.
  - The slave shares ARESETN.

## Configuration
- Macro: COINC_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WR_RESP/RD_RESP.
  - After C_TIMEOUT cycles without BVALID/RVALID, issue rsp_valid with rsp_resp=2'b10 (SLVERR) and rsp_rdata=0.
  - Then enter DRAIN, holding BREADY/RREADY until the late response arrives. That response is discarded, and the FSM returns to IDLE.
- Undefined: the FSM waits indefinitely for the response, and no counter or DRAIN state is present.

## Structure
- Package coinc_arb_pkg holds:
  - the state enum
  - response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - the requester-index type
  - register offsets 0x0/0x4/0x8/0xC
- Sub-module coinc_rr_arbiter: two-way round-robin grant logic with a last_grant register, updated only on acceptance.

## Test plan
- Requester 0 writes 0x1, 0x2, 0x3, 0x4 to 0x0/0x4/0x8/0xC, then reads them back -> each rsp_rdata matches, rsp_resp=0, each write completes in 3 cycles with a zero-wait slave.
- Both requesters are valid at once in every cycle for 4 transactions -> grants alternate 0,1,0,1 and no requester is starved.
- Slave delays WREADY by 3 cycles and asserts AWREADY immediately -> AWVALID drops after 1 cycle, WVALID is held 4 cycles, exactly one BREADY handshake occurs.
- Request req_addr=0x5 -> M_AXI_AWADDR=0x4.
- Assert ARESETN low in RD_RESP -> all outputs are 0 the next cycle, no rsp_valid, and a subsequent read succeeds.
- With COINC_ARB_TIMEOUT_EN and C_TIMEOUT=8, the slave never asserts BVALID -> rsp_resp=2'b10 after 8 wait cycles. A late BVALID is drained without a second rsp_valid.
